alu_interface: RTL and testbench
================================

# alu_interface

Sequencer on the operand side of the ALU. It collects three bytes from the UART receiver (operand A, operand B, opcode) and drives them onto the ALU's `i_dato_a` / `i_dato_b` / `i_op_code` inputs. It then captures the ALU's combinational `o_resultado` one cycle later and hands it to the UART transmitter as a single byte. It sits in the top level between `uart_rx`, the ALU, and `uart_tx`.

## Interface
- `LEN_DATO`, 8, width of operands, result and UART bytes.
- `LEN_OP`, 6, ALU opcode width; must be ≤ `LEN_DATO`.
- `i_clock` in 1: system clock, all logic on rising edge.
- `i_reset` in 1: synchronous, active-low reset.
- `i_rx_data` in `LEN_DATO`: received byte, valid while `i_rx_done` is high.
- `i_rx_done` in 1: one-cycle pulse, byte received.
- `i_tx_done` in 1: one-cycle pulse, transmitter finished the byte.
- `i_resultado` in `LEN_DATO`: ALU result (combinational from the operand outputs).
- `o_dato_a` out `LEN_DATO`: operand A to the ALU (registered).
- `o_dato_b` out `LEN_DATO`: operand B to the ALU (registered).
- `o_op_code` out `LEN_OP`: opcode to the ALU (registered).
- `o_tx_data` out `LEN_DATO`: latched result byte for the transmitter.
- `o_tx_start` out 1: one-cycle pulse requesting transmission.
- `o_busy` out 1: high in CALC, SEND and WAIT_TX; incoming bytes are dropped while high.

## Operation
- **FSM states:** WAIT_A, WAIT_B, WAIT_OP, CALC, SEND, WAIT_TX.
- **WAIT_A:** on `i_rx_done`, load `o_dato_a` ← `i_rx_data` and go to WAIT_B.
- **WAIT_B:** on `i_rx_done`, load `o_dato_b` ← `i_rx_data` and go to WAIT_OP.
- **WAIT_OP:** on `i_rx_done`, load `o_op_code` ← `i_rx_data[LEN_OP-1:0]` and go to CALC.
  - Upper bits of the opcode byte are discarded.
  - The opcode is not validated; unsupported codes are forwarded and the ALU's output is sent as-is.
- **CALC:** one cycle for the ALU to settle. Unconditionally:
  - `o_tx_data` ← `i_resultado`;
  - `o_tx_start` ← 1;
  - go to SEND.
- **SEND:** `o_tx_start` is high for exactly this cycle; go to WAIT_TX.
- **WAIT_TX:** on `i_tx_done`, go to WAIT_A.
- **Operand persistence:** operands and opcode hold their values until overwritten by the next sequence, so the ALU output stays stable during transmission.
- **`i_rx_done` in CALC / SEND / WAIT_TX:** byte discarded, no state change.
- **`i_tx_done` outside WAIT_TX:** ignored.
- **`i_rx_done` and `i_tx_done` in the same cycle in WAIT_TX:** the transition to WAIT_A is taken and the rx byte is dropped.
- **Reset (`i_reset` = 0 at a rising edge), including mid-sequence:**
  - state → WAIT_A;
  - `o_dato_a`, `o_dato_b`, `o_tx_data` = 0;
  - `o_op_code` = 0;
  - `o_tx_start` = 0, `o_busy` = 0.
- **Arithmetic:** the block performs none; all data paths are straight registers of the stated widths.

## Timing
- **Operand visibility:** `o_dato_a` / `o_dato_b` / `o_op_code` update on the edge that samples the corresponding `i_rx_done` high.
- **Result latency:** opcode `i_rx_done` sampled at edge k →
  - `o_op_code` valid after edge k;
  - `o_tx_data` valid and `o_tx_start` high after edge k+1;
  - `o_tx_start` low again after edge k+2.
- **`o_busy` timing:** high from edge k until the edge that samples `i_tx_done`.
- **Back-to-back sequences:** a new A byte is accepted from the cycle after `i_tx_done` is sampled.
- **Input assumptions:** no combinational path from inputs to `o_tx_start` or `o_busy`; all outputs are registered or decoded from state flops only.

## Structure
- **Shared package `alu_pkg`** holds:
  - `LEN_DATO` and `LEN_OP` defaults;
  - opcode constants: ADD 6'b100000, SUB 6'b100010, AND 6'b100100, OR 6'b100101, XOR 6'b100110, SRA 6'b000011, SRL 6'b000010, NOR 6'b100111;
  - the FSM state encoding.
- **Sub-modules:** none. A single FSM plus registers.
- **Placement:** the ALU, `uart_rx` and `uart_tx` are instantiated beside this block in the top level, not inside it.

## Test plan
- **ADD:** rx 0x05, 0x03, 0x20 → `o_op_code` = 6'b100000; `o_tx_start` pulses once, 2 cycles after the opcode `i_rx_done`, with `o_tx_data` = 0x08.
- **SUB and SRA:**
  - rx 0x03, 0x05, 0x22 → `o_tx_data` = 0xFE;
  - rx 0xA0, 0x02, 0x03 → `o_tx_data` = 0xE8.
- **Opcode masking:** rx 0x0F, 0x3C, 0xE4 → `o_op_code` = 6'b100100, `o_tx_data` = 0x0C.
- **Busy drop:** during WAIT_TX, pulse `i_rx_done` with 0x77, then `i_tx_done`, then rx 0x01, 0x02, 0x25 → 0x77 is ignored and `o_tx_data` = 0x03; a simultaneous rx/tx pulse also drops the rx byte.
- **Reset mid-sequence:** after A=0x55 and B=0x11 are received, drive `i_reset` = 0 for one edge → all outputs 0 and state WAIT_A; the next three bytes form a fresh sequence.
- **Stray `i_tx_done`:** pulse in WAIT_A or WAIT_B → no state change and no `o_tx_start`.

Source files
------------

// File: rtl/alu_pkg.sv
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared widths, ALU opcodes and sequencer state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

  localparam int DEFAULT_LEN_DATO = 8;
  localparam int DEFAULT_LEN_OP   = 6;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SRL = 6'b000010;
  localparam logic [5:0] OP_NOR = 6'b100111;

  typedef enum logic [2:0] {
    ST_WAIT_A  = 3'd0,
    ST_WAIT_B  = 3'd1,
    ST_WAIT_OP = 3'd2,
    ST_CALC    = 3'd3,
    ST_SEND    = 3'd4,
    ST_WAIT_TX = 3'd5
  } seq_state_e;

  // Busy covers everything between the opcode byte and the end of transmission.
  function automatic logic state_is_busy(input seq_state_e st);
    return (st == ST_CALC) || (st == ST_SEND) || (st == ST_WAIT_TX);
  endfunction

endpackage : alu_pkg

`default_nettype wire

// File: rtl/alu_interface.sv
// ============================================================================
//  Module      : alu_interface
//  Description : Collects A, B and opcode bytes from the UART receiver, drives
//                the ALU and hands the captured result to the UART transmitter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_interface
  import alu_pkg::*;
#(
  parameter int LEN_DATO = DEFAULT_LEN_DATO,
  parameter int LEN_OP   = DEFAULT_LEN_OP
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic [LEN_DATO-1:0] i_rx_data,
  input  logic                i_rx_done,
  input  logic                i_tx_done,
  input  logic [LEN_DATO-1:0] i_resultado,
  output logic [LEN_DATO-1:0] o_dato_a,
  output logic [LEN_DATO-1:0] o_dato_b,
  output logic [LEN_OP-1:0]   o_op_code,
  output logic [LEN_DATO-1:0] o_tx_data,
  output logic                o_tx_start,
  output logic                o_busy
);

  seq_state_e          state_q,    state_d;
  logic [LEN_DATO-1:0] dato_a_q,   dato_a_d;
  logic [LEN_DATO-1:0] dato_b_q,   dato_b_d;
  logic [LEN_OP-1:0]   op_code_q,  op_code_d;
  logic [LEN_DATO-1:0] tx_data_q,  tx_data_d;
  logic                tx_start_q, tx_start_d;

  always_comb begin
    state_d    = state_q;
    dato_a_d   = dato_a_q;
    dato_b_d   = dato_b_q;
    op_code_d  = op_code_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;

    case (state_q)
      ST_WAIT_A: begin
        if (i_rx_done) begin
          dato_a_d = i_rx_data;
          state_d  = ST_WAIT_B;
        end
      end
      ST_WAIT_B: begin
        if (i_rx_done) begin
          dato_b_d = i_rx_data;
          state_d  = ST_WAIT_OP;
        end
      end
      ST_WAIT_OP: begin
        // Upper bits of the opcode byte are dropped by the width cast.
        if (i_rx_done) begin
          op_code_d = LEN_OP'(i_rx_data);
          state_d   = ST_CALC;
        end
      end
      ST_CALC: begin
        tx_data_d  = i_resultado;
        tx_start_d = 1'b1;
        state_d    = ST_SEND;
      end
      ST_SEND: begin
        state_d = ST_WAIT_TX;
      end
      ST_WAIT_TX: begin
        if (i_tx_done) begin
          state_d = ST_WAIT_A;
        end
      end
      default: begin
        state_d = ST_WAIT_A;
      end
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state_q    <= ST_WAIT_A;
      dato_a_q   <= '0;
      dato_b_q   <= '0;
      op_code_q  <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      dato_a_q   <= dato_a_d;
      dato_b_q   <= dato_b_d;
      op_code_q  <= op_code_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
    end
  end

  assign o_dato_a   = dato_a_q;
  assign o_dato_b   = dato_b_q;
  assign o_op_code  = op_code_q;
  assign o_tx_data  = tx_data_q;
  assign o_tx_start = tx_start_q;
  assign o_busy     = state_is_busy(state_q);

endmodule : alu_interface

`default_nettype wire

// File: tb/tb_alu_interface.sv
// ============================================================================
//  Module      : tb_alu_interface
//  Description : Randomized self-checking bench for alu_interface.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_interface;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       i_reset;
  logic [7:0] i_rx_data;
  logic       i_rx_done;
  logic       i_tx_done;
  logic [7:0] i_resultado;
  logic [7:0] o_dato_a;
  logic [7:0] o_dato_b;
  logic [5:0] o_op_code;
  logic [7:0] o_tx_data;
  logic       o_tx_start;
  logic       o_busy;

  int n_checks = 0;
  int n_errors = 0;
  int pulses;

  logic [7:0] exp_a, exp_b, exp_tx;
  logic [5:0] exp_op;

  always #5 clk = ~clk;

  alu_interface #(.LEN_DATO(8), .LEN_OP(6)) dut (
    .i_clock     (clk),
    .i_reset     (i_reset),
    .i_rx_data   (i_rx_data),
    .i_rx_done   (i_rx_done),
    .i_tx_done   (i_tx_done),
    .i_resultado (i_resultado),
    .o_dato_a    (o_dato_a),
    .o_dato_b    (o_dato_b),
    .o_op_code   (o_op_code),
    .o_tx_data   (o_tx_data),
    .o_tx_start  (o_tx_start),
    .o_busy      (o_busy)
  );

  // Behavioural ALU: both the environment and the source of expected results.
  function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                         input logic [5:0] op);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_SRA:  return 8'($signed(a) >>> b);
      OP_SRL:  return a >> b;
      OP_NOR:  return ~(a | b);
      default: return 8'h00;
    endcase
  endfunction

  assign i_resultado = alu_ref(o_dato_a, o_dato_b, o_op_code);

  task automatic check_value(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (o_tx_start) pulses++;
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_rx_data = b;
    i_rx_done = 1'b1;
    tick();
    i_rx_done = 1'b0;
    i_rx_data = 8'($urandom);
  endtask

  // Idle cycles in a WAIT state, optionally with stray tx_done pulses.
  task automatic idle_gap(input int n, input bit stray);
    for (int i = 0; i < n; i++) begin
      i_tx_done = stray && ($urandom_range(0, 1) == 1);
      tick();
      i_tx_done = 1'b0;
    end
  endtask

  task automatic check_all_outputs(input string tag);
    check_value({tag, "_a"},     32'(o_dato_a),   32'(exp_a));
    check_value({tag, "_b"},     32'(o_dato_b),   32'(exp_b));
    check_value({tag, "_op"},    32'(o_op_code),  32'(exp_op));
    check_value({tag, "_txd"},   32'(o_tx_data),  32'(exp_tx));
    check_value({tag, "_start"}, 32'(o_tx_start), 32'd0);
    check_value({tag, "_busy"},  32'(o_busy),     32'd0);
  endtask

  // drop_mode: 0 none, 1 rx byte inside WAIT_TX, 2 rx and tx_done together.
  task automatic run_seq(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] opb, input int drop_mode, input bit stray);
    pulses = 0;
    send_byte(a);
    exp_a = a;
    check_value("load_a", 32'(o_dato_a), 32'(exp_a));
    check_value("busy_after_a", 32'(o_busy), 32'd0);
    idle_gap($urandom_range(0, 2), stray);
    send_byte(b);
    exp_b = b;
    check_value("load_b", 32'(o_dato_b), 32'(exp_b));
    check_value("hold_a", 32'(o_dato_a), 32'(exp_a));
    idle_gap($urandom_range(0, 2), stray);
    send_byte(opb);
    exp_op = opb[5:0];
    check_value("load_op", 32'(o_op_code), 32'(exp_op));
    check_value("busy_calc", 32'(o_busy), 32'd1);
    check_value("start_calc", 32'(o_tx_start), 32'd0);
    tick();
    exp_tx = alu_ref(a, b, exp_op);
    check_value("start_send", 32'(o_tx_start), 32'd1);
    check_value("tx_data", 32'(o_tx_data), 32'(exp_tx));
    tick();
    check_value("start_end", 32'(o_tx_start), 32'd0);
    check_value("busy_wait", 32'(o_busy), 32'd1);
    if (drop_mode == 1) begin
      send_byte(8'h77);
      check_value("drop_busy", 32'(o_busy), 32'd1);
      check_value("drop_a", 32'(o_dato_a), 32'(exp_a));
    end
    idle_gap($urandom_range(0, 3), 1'b0);
    check_value("busy_hold", 32'(o_busy), 32'd1);
    i_tx_done = 1'b1;
    if (drop_mode == 2) begin
      i_rx_done = 1'b1;
      i_rx_data = 8'h99;
    end
    tick();
    i_tx_done = 1'b0;
    i_rx_done = 1'b0;
    check_value("busy_done", 32'(o_busy), 32'd0);
    check_value("pulse_count", 32'(pulses), 32'd1);
    check_value("persist_a", 32'(o_dato_a), 32'(exp_a));
    check_value("persist_txd", 32'(o_tx_data), 32'(exp_tx));
  endtask

  initial begin
    logic [5:0] ops [8];
    logic [7:0] ra, rb, rop;
    ops = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SRA, OP_SRL, OP_NOR};

    i_reset   = 1'b0;
    i_rx_done = 1'b0;
    i_tx_done = 1'b0;
    i_rx_data = 8'h00;
    exp_a = 8'h00; exp_b = 8'h00; exp_op = 6'h00; exp_tx = 8'h00;
    pulses = 0;
    tick();
    tick();
    check_all_outputs("reset");
    i_reset = 1'b1;
    tick();

    // Directed cases.
    run_seq(8'h05, 8'h03, 8'h20, 0, 1'b0);
    check_value("add_op", 32'(o_op_code), 32'(6'b100000));
    check_value("add_res", 32'(o_tx_data), 32'h08);
    run_seq(8'h03, 8'h05, 8'h22, 0, 1'b0);
    check_value("sub_res", 32'(o_tx_data), 32'hFE);
    run_seq(8'hA0, 8'h02, 8'h03, 0, 1'b0);
    check_value("sra_res", 32'(o_tx_data), 32'hE8);
    run_seq(8'h0F, 8'h3C, 8'hE4, 0, 1'b0);
    check_value("mask_op", 32'(o_op_code), 32'(6'b100100));
    check_value("mask_res", 32'(o_tx_data), 32'h0C);
    run_seq(8'h10, 8'h20, 8'h20, 1, 1'b0);
    run_seq(8'h01, 8'h02, 8'h25, 0, 1'b0);
    check_value("drop_res", 32'(o_tx_data), 32'h03);
    run_seq(8'h44, 8'h11, 8'h26, 2, 1'b0);
    run_seq(8'h09, 8'h01, 8'h20, 0, 1'b1);

    // Stray tx_done in WAIT_A must not start anything.
    pulses = 0;
    i_tx_done = 1'b1;
    tick();
    i_tx_done = 1'b0;
    tick();
    check_value("stray_busy", 32'(o_busy), 32'd0);
    check_value("stray_pulse", 32'(pulses), 32'd0);

    // Reset mid-sequence, then a fresh sequence.
    send_byte(8'h55);
    send_byte(8'h11);
    i_reset = 1'b0;
    tick();
    i_reset = 1'b1;
    exp_a = 8'h00; exp_b = 8'h00; exp_op = 6'h00; exp_tx = 8'h00;
    check_all_outputs("mid_reset");
    run_seq(8'h21, 8'h12, 8'h20, 0, 1'b0);
    check_value("after_reset_res", 32'(o_tx_data), 32'h33);

    // Randomized sequences.
    for (int n = 0; n < 40; n++) begin
      ra = 8'($urandom);
      rb = (($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 7)) : 8'($urandom));
      if ($urandom_range(0, 7) == 0) rop = 8'($urandom);
      else rop = {2'($urandom), ops[$urandom_range(0, 7)]};
      run_seq(ra, rb, rop, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_alu_interface

`default_nettype wire
